fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
- Sequencer placed in front of the 8-tap, 2-bit-coefficient FIR.
- Shares the FIR's single 6-bit input bus between two requesters: a coefficient loader (host) and a sample stream.
- Drives the FIR's set-coefficients strobe and tvalid, and blanks FIR output during pipeline warm-up.
- Presents a qualified result stream (out_data/out_valid) with a beat counter.

Parameters:
- CFG_WORDS, 3, number of 6-bit coefficient words per load (3 taps per word, packed MSB-first).
- WARM_CYCLES, 11, consecutive valid samples in RUN before FIR output is declared valid (1 input reg + 8 delay + multiply + sum, rounded).
- CNT_W, 8, width of out_count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_start  in  1  pulse: begin coefficient load
- cfg_word  in  6  packed coefficient word (taps [5:4],[3:2],[1:0])
- cfg_valid  in  1  cfg_word valid
- cfg_ready  out  1  controller accepts cfg_word this cycle
- run_stop  in  1  pulse: leave RUN, return to IDLE
- smp_data  in  6  signed input sample
- smp_valid  in  1  sample valid
- smp_ready  out  1  controller accepts sample this cycle
- fir_tdata  out  6  muxed bus to FIR data input
- fir_tvalid  out  1  to FIR tvalid
- fir_set_coeffs  out  1  to FIR set-coefficients strobe
- fir_result  in  8  signed FIR output
- out_data  out  8  qualified filter result
- out_valid  out  1  out_data valid
- out_count  out  CNT_W  number of out_valid beats since last entry to RUN, wraps
- state  out  2  IDLE=0, LOAD=1, SETTLE=2, RUN=3

Behaviour:
- Reset is asserted asynchronously. All outputs go to 0 and state goes to IDLE; the word counter and warm counter clear. The FIR shares the reset net, so its taps return to their defaults at the same time.
- All outputs are registered. Decisions are made on current inputs and take effect on the FIR pins next cycle.
- IDLE:
  - cfg_ready=0, smp_ready=0, fir_tvalid=0, fir_set_coeffs=0.
  - cfg_start -> LOAD with word counter cleared.
  - smp_valid is ignored.
- LOAD:
  - cfg_ready=1.
  - On each cfg_valid&&cfg_ready: fir_tdata<=cfg_word, fir_set_coeffs<=1, counter++.
  - Cycles without cfg_valid: fir_set_coeffs<=0 and fir_tdata holds (gaps allowed).
  - When the accepted word is number CFG_WORDS-1: cfg_ready<=0 and go to SETTLE.
  - cfg_start is ignored while in LOAD.
  - run_stop -> IDLE (partial load; the FIR keeps whatever shifted in).
- SETTLE:
  - Exactly one cycle; fir_set_coeffs<=0, fir_tdata<=0.
  - Then -> RUN with warm counter=0 and out_count=0.
- RUN:
  - smp_ready=1; fir_tdata<=smp_data; fir_tvalid<=smp_valid.
  - The warm counter increments on each smp_valid and saturates at WARM_CYCLES.
  - smp_valid=0 clears the warm counter, because the FIR restarts its enable on a tvalid drop.
  - out_valid<=1 iff fir_tvalid was 1 in the previous cycle and the warm counter == WARM_CYCLES; out_data<=fir_result when out_valid is set, otherwise it holds.
  - out_count increments on each out_valid beat and wraps at 2^CNT_W.
- Exit from RUN:
  - cfg_start -> LOAD. Same cycle: smp_ready<=0, fir_tvalid<=0, out_valid<=0, warm counter cleared.
  - run_stop -> IDLE with the same clears.
  - If run_stop and cfg_start arrive together, run_stop wins.
- Bus exclusivity: fir_set_coeffs and fir_tvalid are never 1 in the same cycle.
- cfg_ready and smp_ready are never 1 in the same cycle.
- out_valid is 0 in every state except RUN.

Test Plan:
- Reset, then check outputs: all outputs 0, state=0. Then cfg_start with words 0x15, 0x00, 0x2A on consecutive cycles -> fir_set_coeffs high for exactly 3 cycles carrying 0x15, 0x00, 0x2A; then state goes 2 then 3 and smp_ready=1.
- In LOAD, apply cfg_valid pattern 1,0,0,1,1 -> exactly 3 strobes, fir_tdata held during the gaps, SETTLE entered after the third accept.
- In RUN, stream smp_data=5 continuously -> out_valid first rises on the cycle after the 11th valid sample; out_data=fir_result; out_count counts 1,2,3…
- In RUN, drop smp_valid for 1 cycle mid-stream -> out_valid falls next cycle and stays low until 11 further consecutive valid samples.
- In RUN, assert cfg_start and run_stop in the same cycle -> state=IDLE, fir_tvalid=0, out_valid=0, no set_coeffs strobe.
- Assert reset mid-LOAD after 1 word -> immediate async clear to IDLE; a subsequent full load completes normally; out_count wraps 255 -> 0 under a long stream.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Sequencer in front of the 8-tap FIR: arbitrates the shared 6-bit input bus between
// the coefficient loader and the sample stream, and qualifies FIR output after warm-up.
module fir_seq_ctrl #(
    parameter int CFG_WORDS   = 3,
    parameter int WARM_CYCLES = 11,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic [5:0]              cfg_word,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    run_stop,
    input  logic signed [5:0]       smp_data,
    input  logic                    smp_valid,
    output logic                    smp_ready,
    output logic signed [5:0]       fir_tdata,
    output logic                    fir_tvalid,
    output logic                    fir_set_coeffs,
    input  logic signed [7:0]       fir_result,
    output logic signed [7:0]       out_data,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        out_count,
    output logic [1:0]              state
);

    localparam int WCNT_W = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
    localparam int WARM_W = $clog2(WARM_CYCLES + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(CFG_WORDS - 1);
    localparam logic [WARM_W-1:0] WARM_MAX  = WARM_W'(WARM_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t              st;
    logic [WCNT_W-1:0]   word_cnt;
    logic [WARM_W-1:0]   warm_cnt;

    function automatic logic [WARM_W-1:0] warm_sat_inc(input logic [WARM_W-1:0] w);
        return (w == WARM_MAX) ? w : w + 1'b1;
    endfunction

    assign state = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st             <= S_IDLE;
            word_cnt       <= '0;
            warm_cnt       <= '0;
            cfg_ready      <= 1'b0;
            smp_ready      <= 1'b0;
            fir_tdata      <= '0;
            fir_tvalid     <= 1'b0;
            fir_set_coeffs <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_count      <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    cfg_ready      <= 1'b0;
                    smp_ready      <= 1'b0;
                    fir_tvalid     <= 1'b0;
                    fir_set_coeffs <= 1'b0;
                    out_valid      <= 1'b0;
                    if (cfg_start) begin
                        st        <= S_LOAD;
                        word_cnt  <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A stop abandons a partial load; taps already shifted into the FIR stay.
                    if (run_stop) begin
                        st             <= S_IDLE;
                        cfg_ready      <= 1'b0;
                        fir_set_coeffs <= 1'b0;
                    end else if (cfg_valid && cfg_ready) begin
                        fir_tdata      <= $signed(cfg_word);
                        fir_set_coeffs <= 1'b1;
                        word_cnt       <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            cfg_ready <= 1'b0;
                            st        <= S_SETTLE;
                        end
                    end else begin
                        fir_set_coeffs <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    fir_set_coeffs <= 1'b0;
                    fir_tdata      <= '0;
                    warm_cnt       <= '0;
                    out_count      <= '0;
                    smp_ready      <= 1'b1;
                    st             <= S_RUN;
                end
                S_RUN: begin
                    if (run_stop || cfg_start) begin
                        smp_ready  <= 1'b0;
                        fir_tvalid <= 1'b0;
                        out_valid  <= 1'b0;
                        warm_cnt   <= '0;
                        if (run_stop) begin
                            st <= S_IDLE;
                        end else begin
                            st        <= S_LOAD;
                            word_cnt  <= '0;
                            cfg_ready <= 1'b1;
                        end
                    end else begin
                        fir_tdata  <= smp_data;
                        fir_tvalid <= smp_valid;
                        // The FIR restarts its enable chain on any tvalid gap, so warm-up restarts too.
                        warm_cnt   <= smp_valid ? warm_sat_inc(warm_cnt) : '0;
                        out_valid  <= fir_tvalid && (warm_cnt == WARM_MAX);
                        if (fir_tvalid && (warm_cnt == WARM_MAX)) begin
                            out_data  <= fir_result;
                            out_count <= out_count + 1'b1;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: load sequencing, warm-up qualification, exits and reset.
module tb_fir_seq_ctrl;

    logic              clk;
    logic              reset;
    logic              cfg_start;
    logic [5:0]        cfg_word;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              run_stop;
    logic signed [5:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;
    logic signed [5:0] fir_tdata;
    logic              fir_tvalid;
    logic              fir_set_coeffs;
    logic signed [7:0] fir_result;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic [7:0]        out_count;
    logic [1:0]        state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam bit         GAP_VLD  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [5:0] GAP_WORD [5] = '{6'h01, 6'h3F, 6'h3F, 6'h02, 6'h03};
    localparam logic [5:0] GAP_TD   [5] = '{6'h01, 6'h01, 6'h01, 6'h02, 6'h03};
    localparam logic [1:0] GAP_ST   [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

    fir_seq_ctrl #(.CFG_WORDS(3), .WARM_CYCLES(11), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .run_stop(run_stop),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .fir_tdata(fir_tdata), .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs),
        .fir_result(fir_result),
        .out_data(out_data), .out_valid(out_valid), .out_count(out_count),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg_start = 0; cfg_word = 0; cfg_valid = 0; run_stop = 0;
        smp_data = 0; smp_valid = 0; fir_result = 0;
        #2;
        n_checks++;
        if ({cfg_ready, smp_ready, fir_tdata, fir_tvalid, fir_set_coeffs, out_data, out_valid, out_count} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0",
                {cfg_ready, smp_ready, fir_tdata, fir_tvalid, fir_set_coeffs, out_data, out_valid, out_count});
        end
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
    endtask

    // Full load of three words on consecutive cycles, then SETTLE and RUN entry.
    task automatic do_full_load(input string tag);
        logic [5:0] words [3];
        words = '{6'h15, 6'h00, 6'h2A};
        cfg_start = 1; step(); cfg_start = 0;
        n_checks++;
        if ({state, cfg_ready, fir_set_coeffs} !== {2'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL %s_enter_load: got st=%0d rdy=%b set=%b want 1 1 0", tag, state, cfg_ready, fir_set_coeffs);
        end
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1; cfg_word = words[i]; step();
            n_checks++;
            if ({fir_set_coeffs, fir_tdata} !== {1'b1, words[i]}) begin
                n_fail++; $display("FAIL %s_word%0d: got set=%b td=%h want 1 %h", tag, i, fir_set_coeffs, fir_tdata, words[i]);
            end
        end
        cfg_valid = 0;
        n_checks++;
        if ({state, cfg_ready} !== {2'd2, 1'b0}) begin
            n_fail++; $display("FAIL %s_settle: got st=%0d rdy=%b want 2 0", tag, state, cfg_ready);
        end
        step();
        n_checks++;
        if ({state, smp_ready, fir_set_coeffs, fir_tdata, fir_tvalid} !== {2'd3, 1'b1, 1'b0, 6'h00, 1'b0}) begin
            n_fail++; $display("FAIL %s_run: got st=%0d srdy=%b set=%b td=%h tv=%b want 3 1 0 00 0",
                tag, state, smp_ready, fir_set_coeffs, fir_tdata, fir_tvalid);
        end
    endtask

    task automatic test_load_basic();
        do_full_load("basic");
        run_stop = 1; step(); run_stop = 0;
        n_checks++;
        if ({state, smp_ready} !== {2'd0, 1'b0}) begin
            n_fail++; $display("FAIL basic_stop: got st=%0d srdy=%b want 0 0", state, smp_ready);
        end
    endtask

    task automatic test_load_gaps();
        int strobes = 0;
        cfg_start = 1; step(); cfg_start = 0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = GAP_VLD[i]; cfg_word = GAP_WORD[i]; step();
            strobes += int'(fir_set_coeffs);
            n_checks++;
            if ({fir_set_coeffs, fir_tdata, state} !== {GAP_VLD[i], GAP_TD[i], GAP_ST[i]}) begin
                n_fail++; $display("FAIL gap_cycle%0d: got set=%b td=%h st=%0d want %b %h %0d",
                    i, fir_set_coeffs, fir_tdata, state, GAP_VLD[i], GAP_TD[i], GAP_ST[i]);
            end
        end
        cfg_valid = 0;
        n_checks++;
        if (strobes !== 3) begin n_fail++; $display("FAIL gap_strobes: got %0d want 3", strobes); end
        step();
        n_checks++;
        if (state !== 2'd3) begin n_fail++; $display("FAIL gap_run: got %0d want 3", state); end
    endtask

    // Streaming from the first RUN cycle: out_valid appears at the 12th edge.
    task automatic test_stream();
        logic signed [7:0] exp_res;
        smp_valid = 1; smp_data = 6'sd5;
        for (int i = 1; i <= 30; i++) begin
            exp_res = 8'(i * 7 - 40);
            fir_result = exp_res;
            step();
            n_checks++;
            if ({fir_tvalid, fir_tdata, fir_set_coeffs} !== {1'b1, 6'sd5, 1'b0}) begin
                n_fail++; $display("FAIL stream_bus%0d: got tv=%b td=%h set=%b want 1 05 0", i, fir_tvalid, fir_tdata, fir_set_coeffs);
            end
            n_checks++;
            if ({out_valid, out_count} !== {(i >= 12), 8'((i >= 12) ? i - 11 : 0)}) begin
                n_fail++; $display("FAIL stream_ov%0d: got ov=%b cnt=%0d want %b %0d",
                    i, out_valid, out_count, (i >= 12), (i >= 12) ? i - 11 : 0);
            end
            if (i >= 12) begin
                n_checks++;
                if (out_data !== exp_res) begin
                    n_fail++; $display("FAIL stream_data%0d: got %0d want %0d", i, out_data, exp_res);
                end
            end
        end
    endtask

    task automatic test_drop();
        smp_valid = 0; step();
        n_checks++;
        if ({fir_tvalid, out_valid, out_count} !== {1'b0, 1'b1, 8'd20}) begin
            n_fail++; $display("FAIL drop_edge: got tv=%b ov=%b cnt=%0d want 0 1 20", fir_tvalid, out_valid, out_count);
        end
        smp_valid = 1;
        for (int j = 1; j <= 14; j++) begin
            step();
            n_checks++;
            if (out_valid !== (j >= 12)) begin
                n_fail++; $display("FAIL drop_ov%0d: got %b want %b", j, out_valid, (j >= 12));
            end
        end
        n_checks++;
        if (out_count !== 8'd23) begin n_fail++; $display("FAIL drop_count: got %0d want 23", out_count); end
    endtask

    task automatic test_exit_both();
        cfg_start = 1; run_stop = 1; step(); cfg_start = 0; run_stop = 0; smp_valid = 0;
        n_checks++;
        if ({state, fir_tvalid, out_valid, fir_set_coeffs, smp_ready, cfg_ready} !== {2'd0, 5'b0}) begin
            n_fail++; $display("FAIL both_exit: got st=%0d tv=%b ov=%b set=%b srdy=%b crdy=%b want 0 0 0 0 0 0",
                state, fir_tvalid, out_valid, fir_set_coeffs, smp_ready, cfg_ready);
        end
        step();
        n_checks++;
        if ({state, fir_set_coeffs} !== {2'd0, 1'b0}) begin
            n_fail++; $display("FAIL both_hold: got st=%0d set=%b want 0 0", state, fir_set_coeffs);
        end
    endtask

    task automatic test_reset_mid_load();
        cfg_start = 1; step(); cfg_start = 0;
        cfg_valid = 1; cfg_word = 6'h07; step(); cfg_valid = 0;
        n_checks++;
        if ({fir_set_coeffs, fir_tdata} !== {1'b1, 6'h07}) begin
            n_fail++; $display("FAIL midrst_word: got set=%b td=%h want 1 07", fir_set_coeffs, fir_tdata);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({state, fir_set_coeffs, cfg_ready, fir_tdata} !== {2'd0, 1'b0, 1'b0, 6'h00}) begin
            n_fail++; $display("FAIL midrst_clear: got st=%0d set=%b rdy=%b td=%h want 0 0 0 00",
                state, fir_set_coeffs, cfg_ready, fir_tdata);
        end
        reset = 1'b1;
        do_full_load("reload");
    endtask

    task automatic test_wrap();
        smp_valid = 1; smp_data = -6'sd3;
        for (int i = 1; i <= 270; i++) begin
            fir_result = 8'(i);
            step();
            if (i >= 12) begin
                n_checks++;
                if ({out_valid, out_count} !== {1'b1, 8'(i - 11)}) begin
                    n_fail++; $display("FAIL wrap_cnt%0d: got ov=%b cnt=%0d want 1 %0d", i, out_valid, out_count, 8'(i - 11));
                end
            end
        end
        cfg_start = 1; step(); cfg_start = 0; smp_valid = 0;
        n_checks++;
        if ({state, cfg_ready, smp_ready, fir_tvalid, out_valid} !== {2'd1, 1'b1, 3'b000}) begin
            n_fail++; $display("FAIL wrap_to_load: got st=%0d crdy=%b srdy=%b tv=%b ov=%b want 1 1 0 0 0",
                state, cfg_ready, smp_ready, fir_tvalid, out_valid);
        end
        run_stop = 1; step(); run_stop = 0;
        n_checks++;
        if ({state, cfg_ready, out_valid} !== {2'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL wrap_stop: got st=%0d crdy=%b ov=%b want 0 0 0", state, cfg_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_gaps();
        test_stream();
        test_drop();
        test_exit_both();
        test_reset_mid_load();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
